// File: rtl/vga_bg_render.sv
// Two-stage background renderer: sky above GROUND_Y, scrolling checkerboard below.
// Horizontal scroll offset advances once per frame on the rising edge of vsync.
`timescale 1ns/1ps
module vga_bg_render #(
  parameter int          MIN_X     = 64,
  parameter int          MIN_Y     = 16,
  parameter int          GROUND_Y  = 400,
  parameter logic [23:0] SKY_RGB   = 24'hAABBCC,
  parameter logic [23:0] GND_A_RGB = 24'h8B4513,
  parameter logic [23:0] GND_B_RGB = 24'h228B22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] CounterX,
  input  logic [9:0] CounterY,
  input  logic       inDisplayArea,
  input  logic       vga_h_sync_in,
  input  logic       vga_v_sync_in,
  input  logic       scroll_en,
  input  logic [3:0] scroll_step,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_h_sync,
  output logic       vga_v_sync,
  output logic       pixel_valid,
  output logic       frame_tick,
  output logic [9:0] scroll_x
);

  localparam logic [10:0] LINE_W = 11'd640;

  // vld_pipe_q[0] is stage 1, vld_pipe_q[1] is the output stage
  logic [1:0]  vld_pipe_q;
  logic [1:0]  hs_pipe_q, vs_pipe_q;
  logic [9:0]  s1_y_q, s1_wx_q;
  logic [23:0] rgb_q, rgb_d;
  logic [9:0]  scroll_x_q, scroll_x_d;
  logic        vsin_q;

  logic [9:0]  x_d, y_d, wx_d;
  logic [10:0] wsum, ssum;

  always_comb begin
    x_d  = CounterX - 10'(MIN_X);
    y_d  = CounterY - 10'(MIN_Y);
    wsum = {1'b0, x_d} + {1'b0, scroll_x_q};
    wx_d = (wsum >= LINE_W) ? 10'(wsum - LINE_W) : wsum[9:0];
  end

  always_comb begin
    rgb_d = 24'h000000;
    if (vld_pipe_q[0]) begin
      if (s1_y_q < 10'(GROUND_Y))        rgb_d = SKY_RGB;
      else if (s1_wx_q[5] ^ s1_y_q[5])   rgb_d = GND_A_RGB;
      else                               rgb_d = GND_B_RGB;
    end
  end

  // vsin_q resets high so a vsync already high at release is not an edge
  assign frame_tick = vga_v_sync_in & ~vsin_q;

  always_comb begin
    ssum       = {1'b0, scroll_x_q} + 11'(scroll_step);
    scroll_x_d = scroll_x_q;
    if (frame_tick && scroll_en)
      scroll_x_d = (ssum >= LINE_W) ? 10'(ssum - LINE_W) : ssum[9:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
      s1_y_q     <= '0;
      s1_wx_q    <= '0;
      rgb_q      <= '0;
      scroll_x_q <= '0;
      vsin_q     <= 1'b1;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], inDisplayArea};
      hs_pipe_q  <= {hs_pipe_q[0], vga_h_sync_in};
      vs_pipe_q  <= {vs_pipe_q[0], vga_v_sync_in};
      s1_y_q     <= y_d;
      s1_wx_q    <= wx_d;
      rgb_q      <= rgb_d;
      scroll_x_q <= scroll_x_d;
      vsin_q     <= vga_v_sync_in;
    end
  end

  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign pixel_valid = vld_pipe_q[1];
  assign vga_h_sync  = hs_pipe_q[1];
  assign vga_v_sync  = vs_pipe_q[1];
  assign scroll_x    = scroll_x_q;

endmodule

// File: tb/tb_vga_bg_render.sv
// Directed bench for vga_bg_render: table of pixel vectors plus scroll/reset sequences.
`timescale 1ns/1ps
module tb_vga_bg_render;

  localparam logic [23:0] SKY = 24'hAABBCC;
  localparam logic [23:0] GA  = 24'h8B4513;
  localparam logic [23:0] GB  = 24'h228B22;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] CounterX, CounterY;
  logic       inDisplayArea, vga_h_sync_in, vga_v_sync_in, scroll_en;
  logic [3:0] scroll_step;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_h_sync, vga_v_sync, pixel_valid, frame_tick;
  logic [9:0] scroll_x;

  int n_cmp = 0;
  int n_bad = 0;

  vga_bg_render dut (
    .clk(clk), .reset(reset), .CounterX(CounterX), .CounterY(CounterY),
    .inDisplayArea(inDisplayArea), .vga_h_sync_in(vga_h_sync_in),
    .vga_v_sync_in(vga_v_sync_in), .scroll_en(scroll_en), .scroll_step(scroll_step),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_h_sync(vga_h_sync),
    .vga_v_sync(vga_v_sync), .pixel_valid(pixel_valid), .frame_tick(frame_tick),
    .scroll_x(scroll_x)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  cx, cy;
    logic        disp, hs;
    logic [23:0] rgb;
    logic        pv;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_pix(input logic [9:0] cx, input logic [9:0] cy, input logic disp);
    CounterX = cx;
    CounterY = cy;
    inDisplayArea = disp;
  endtask

  // One vsync rising edge; frame_tick must pulse for exactly one cycle
  task automatic frame(input int exp_scroll);
    vga_v_sync_in = 1'b0;
    tick();
    vga_v_sync_in = 1'b1;
    #1;
    chk("frame_tick_hi", 32'(frame_tick), 32'd1);
    tick();
    chk("frame_tick_lo", 32'(frame_tick), 32'd0);
    chk("scroll_x", 32'(scroll_x), 32'(exp_scroll));
  endtask

  initial begin
    logic hist[16];
    int   mx;

    tbl[0] = '{cx:10'd64,  cy:10'd16,  disp:1'b1, hs:1'b1, rgb:SKY,      pv:1'b1};
    tbl[1] = '{cx:10'd96,  cy:10'd416, disp:1'b1, hs:1'b0, rgb:GA,       pv:1'b1};
    tbl[2] = '{cx:10'd64,  cy:10'd416, disp:1'b1, hs:1'b1, rgb:GB,       pv:1'b1};
    tbl[3] = '{cx:10'd64,  cy:10'd448, disp:1'b1, hs:1'b0, rgb:GA,       pv:1'b1};
    tbl[4] = '{cx:10'd96,  cy:10'd448, disp:1'b1, hs:1'b1, rgb:GB,       pv:1'b1};
    tbl[5] = '{cx:10'd64,  cy:10'd415, disp:1'b1, hs:1'b0, rgb:SKY,      pv:1'b1};
    tbl[6] = '{cx:10'd96,  cy:10'd416, disp:1'b0, hs:1'b1, rgb:24'h0,    pv:1'b0};
    tbl[7] = '{cx:10'd703, cy:10'd495, disp:1'b1, hs:1'b0, rgb:GA,       pv:1'b1};

    reset = 1'b1;
    set_pix(10'd64, 10'd16, 1'b1);
    vga_h_sync_in = 1'b1;
    vga_v_sync_in = 1'b1;
    scroll_en = 1'b0;
    scroll_step = 4'd0;
    tick(); tick();
    chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    chk("rst_pv", 32'(pixel_valid), 32'd0);
    chk("rst_ft", 32'(frame_tick), 32'd0);
    chk("rst_scroll", 32'(scroll_x), 32'd0);
    chk("rst_hs", 32'(vga_h_sync), 32'd0);
    chk("rst_vs", 32'(vga_v_sync), 32'd0);

    reset = 1'b0;
    tick();
    chk("rel_ft", 32'(frame_tick), 32'd0);
    vga_v_sync_in = 1'b0;

    for (int i = 0; i < 8; i++) begin
      set_pix(tbl[i].cx, tbl[i].cy, tbl[i].disp);
      vga_h_sync_in = tbl[i].hs;
      tick(); tick();
      chk($sformatf("vec%0d_rgb", i), 32'({vga_r, vga_g, vga_b}), 32'(tbl[i].rgb));
      chk($sformatf("vec%0d_pv", i), 32'(pixel_valid), 32'(tbl[i].pv));
      chk($sformatf("vec%0d_hs", i), 32'(vga_h_sync), 32'(tbl[i].hs));
    end

    // Blanking with toggling hsync: output is the input two cycles late
    set_pix(10'd100, 10'd100, 1'b0);
    for (int i = 0; i < 16; i++) begin
      hist[i] = ((i % 3) == 0) ^ (i[1]);
      vga_h_sync_in = hist[i];
      tick();
      if (i >= 1) begin
        chk("blank_hs", 32'(vga_h_sync), 32'(hist[i-1]));
        chk("blank_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
        chk("blank_pv", 32'(pixel_valid), 32'd0);
      end
    end

    // Scroll up to 630 in steps of 15; pixel x=27,y=400 is held
    set_pix(10'd91, 10'd416, 1'b1);
    scroll_en = 1'b1;
    scroll_step = 4'd15;
    for (int k = 1; k <= 42; k++) frame(15 * k);

    // 630+15 wraps to 5; new offset reaches pixels one cycle after the tick
    vga_v_sync_in = 1'b0;
    tick();
    vga_v_sync_in = 1'b1;
    #1;
    chk("wrap_ft_hi", 32'(frame_tick), 32'd1);
    tick();
    chk("wrap_ft_lo", 32'(frame_tick), 32'd0);
    chk("wrap_scroll", 32'(scroll_x), 32'd5);
    chk("old_scroll_pix0", 32'({vga_r, vga_g, vga_b}), 32'(GB));
    tick();
    chk("old_scroll_pix1", 32'({vga_r, vga_g, vga_b}), 32'(GB));
    tick();
    chk("new_scroll_pix", 32'({vga_r, vga_g, vga_b}), 32'(GA));

    // Scroll controls ignored away from the tick
    scroll_step = 4'd9;
    scroll_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("hold_scroll", 32'(scroll_x), 32'd5);
    chk("hold_ft", 32'(frame_tick), 32'd0);

    scroll_en = 1'b0;
    frame(5);

    scroll_en = 1'b1;
    scroll_step = 4'd5;
    for (int k = 1; k <= 19; k++) frame(5 + 5 * k);

    // Mid-line asynchronous reset with scroll at 100
    set_pix(10'd64, 10'd16, 1'b1);
    vga_h_sync_in = 1'b1;
    tick(); tick();
    chk("pre_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'(SKY));
    #2;
    reset = 1'b1;
    #1;
    chk("arst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    chk("arst_pv", 32'(pixel_valid), 32'd0);
    chk("arst_scroll", 32'(scroll_x), 32'd0);
    chk("arst_ft", 32'(frame_tick), 32'd0);
    chk("arst_hs", 32'(vga_h_sync), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rel2_ft0", 32'(frame_tick), 32'd0);
    tick();
    chk("rel2_ft1", 32'(frame_tick), 32'd0);
    chk("rel2_scroll", 32'(scroll_x), 32'd0);
    tick();
    chk("rel2_rgb", 32'({vga_r, vga_g, vga_b}), 32'(SKY));
    chk("rel2_pv", 32'(pixel_valid), 32'd1);

    // 160 updates of +4 starting from 0 wrap back to 0
    scroll_step = 4'd4;
    mx = 0;
    for (int k = 1; k <= 160; k++) begin
      frame((4 * k) % 640);
      if (int'(scroll_x) > mx) mx = int'(scroll_x);
    end
    chk("sweep_final", 32'(scroll_x), 32'd0);
    chk("sweep_max", 32'(mx), 32'd636);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
